acc_tile_sequencer: RTL and testbench

- Controller that sequences one accumulator_array through a series of output tiles.
- Per tile:
  - admits K partial-sum waves from the systolic array, flagging the first wave as init data;
  - drains the tile by holding calc_done for SIZE cycles;
  - waits for the array's tile_calc_over pulse, then advances to the next tile.
- Sits between the top-level layer FSM (start/done) and the accumulator_array control inputs.

---
 rtl/acc_tile_sequencer_if.sv | 31 +++
 rtl/acc_tile_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_acc_tile_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_tile_sequencer_if.sv
// Array-side control bundle for acc_tile_sequencer: psum wave handshake, drain
// gating and the accumulator_array control strobes.
interface acc_tile_sequencer_if;
    logic psum_valid_i;
    logic psum_ready_o;
    logic drain_ready_i;
    logic tile_calc_over_i;
    logic acc_input_valid_o;
    logic acc_is_init_data_o;
    logic acc_calc_done_o;

    modport master (
        input  psum_valid_i,
        input  drain_ready_i,
        input  tile_calc_over_i,
        output psum_ready_o,
        output acc_input_valid_o,
        output acc_is_init_data_o,
        output acc_calc_done_o
    );

    modport slave (
        output psum_valid_i,
        output drain_ready_i,
        output tile_calc_over_i,
        input  psum_ready_o,
        input  acc_input_valid_o,
        input  acc_is_init_data_o,
        input  acc_calc_done_o
    );
endinterface

// File: rtl/acc_tile_sequencer.sv
// Sequences one accumulator_array through K-wave accumulate / SIZE-cycle drain per tile.
// Optional WAIT_OVER watchdog with sticky err_o: define ACC_SEQ_WATCHDOG_EN.
module acc_tile_sequencer #(
    parameter int unsigned SIZE    = 16,
    parameter int unsigned K_WIDTH = 16,
    parameter int unsigned T_WIDTH = 12,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [K_WIDTH-1:0]     k_len_i,
    input  logic [T_WIDTH-1:0]     tiles_i,
    input  logic                   clear_i,
    acc_tile_sequencer_if.master   arr,
    output logic [T_WIDTH-1:0]     tile_idx_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int unsigned        DRAIN_W    = $clog2(SIZE) + 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN_WAIT,
        S_DRAIN,
        S_WAIT_OVER,
        S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [K_WIDTH-1:0]   k_len_q, k_len_d;
    logic [T_WIDTH-1:0]   tiles_q, tiles_d;
    logic [K_WIDTH-1:0]   k_cnt_q, k_cnt_d;
    logic [T_WIDTH-1:0]   tile_cnt_q, tile_cnt_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;

    logic                 accept;
    logic                 last_wave;
    logic                 last_tile;

`ifdef ACC_SEQ_WATCHDOG_EN
    localparam int unsigned     WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            err_q, err_d;
`endif

    // Zero-latency pass-through of the systolic array's valid while admitting waves.
    assign accept    = arr.psum_valid_i & (state_q == S_ACCUM);
    assign last_wave = (k_cnt_q == k_len_q - K_WIDTH'(1));
    assign last_tile = (tile_cnt_q == tiles_q - T_WIDTH'(1));

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        tiles_d     = tiles_q;
        k_cnt_d     = k_cnt_q;
        tile_cnt_d  = tile_cnt_q;
        drain_cnt_d = drain_cnt_q;
`ifdef ACC_SEQ_WATCHDOG_EN
        wd_cnt_d    = wd_cnt_q;
        err_d       = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    k_len_d     = k_len_i;
                    tiles_d     = tiles_i;
                    k_cnt_d     = '0;
                    tile_cnt_d  = '0;
                    drain_cnt_d = '0;
`ifdef ACC_SEQ_WATCHDOG_EN
                    err_d       = 1'b0;
`endif
                    if ((k_len_i == '0) || (tiles_i == '0)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end

            S_ACCUM: begin
                if (accept) begin
                    k_cnt_d = k_cnt_q + K_WIDTH'(1);
                    if (last_wave) begin
                        state_d = S_DRAIN_WAIT;
                    end
                end
            end

            S_DRAIN_WAIT: begin
                if (arr.drain_ready_i) begin
                    drain_cnt_d = '0;
                    state_d     = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    drain_cnt_d = '0;
                    state_d     = S_WAIT_OVER;
`ifdef ACC_SEQ_WATCHDOG_EN
                    wd_cnt_d    = '0;
`endif
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end

            S_WAIT_OVER: begin
                if (arr.tile_calc_over_i) begin
                    if (last_tile) begin
                        state_d = S_FIN;
                    end else begin
                        tile_cnt_d = tile_cnt_q + T_WIDTH'(1);
                        k_cnt_d    = '0;
                        state_d    = S_ACCUM;
                    end
                end
`ifdef ACC_SEQ_WATCHDOG_EN
                // A late tile_calc_over_i on the expiry cycle still wins.
                else if (wd_cnt_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
`endif
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Soft abort overrides every transition above but leaves config and err untouched.
        if (clear_i) begin
            state_d     = S_IDLE;
            k_len_d     = k_len_q;
            tiles_d     = tiles_q;
            k_cnt_d     = '0;
            tile_cnt_d  = '0;
            drain_cnt_d = '0;
`ifdef ACC_SEQ_WATCHDOG_EN
            wd_cnt_d    = '0;
            err_d       = err_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            tiles_q     <= '0;
            k_cnt_q     <= '0;
            tile_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            tiles_q     <= tiles_d;
            k_cnt_q     <= k_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

`ifdef ACC_SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_o = err_q;
`else
    // No watchdog built; TIMEOUT only kept so both builds share one parameter list.
    assign err_o = 1'b0 & (TIMEOUT == 0);
`endif

    assign arr.psum_ready_o       = (state_q == S_ACCUM);
    assign arr.acc_input_valid_o  = accept;
    assign arr.acc_is_init_data_o = accept & (k_cnt_q == '0);
    assign arr.acc_calc_done_o    = (state_q == S_DRAIN);

    assign tile_idx_o = tile_cnt_q;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_FIN);

endmodule

// File: tb/tb_acc_tile_sequencer.sv
// Randomized self-checking bench for acc_tile_sequencer against a per-tile
// transaction timeline (accept K waves, drain SIZE cycles, wait for over pulse).
module tb_acc_tile_sequencer;

    localparam int unsigned SIZE = 16;
    localparam int unsigned KW   = 16;
    localparam int unsigned TW   = 12;
`ifdef ACC_SEQ_WATCHDOG_EN
    localparam int unsigned TMO  = 32;
`else
    localparam int unsigned TMO  = 1024;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [KW-1:0] k_len;
    logic [TW-1:0] tiles;
    logic          clear;
    logic [TW-1:0] tile_idx;
    logic          busy;
    logic          done;
    logic          err;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    acc_tile_sequencer_if arr_if ();

    acc_tile_sequencer #(
        .SIZE    (SIZE),
        .K_WIDTH (KW),
        .T_WIDTH (TW),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .k_len_i    (k_len),
        .tiles_i    (tiles),
        .clear_i    (clear),
        .arr        (arr_if),
        .tile_idx_o (tile_idx),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    // Output snapshot: {err, ready, in_valid, init, calc_done, busy, done}
    function automatic logic [6:0] outs();
        return {err, arr_if.psum_ready_o, arr_if.acc_input_valid_o,
                arr_if.acc_is_init_data_o, arr_if.acc_calc_done_o, busy, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulses while busy must be ignored, with junk config attached.
    task automatic rand_start();
        start = ($urandom_range(7, 0) == 0);
        k_len = KW'($urandom);
        tiles = TW'($urandom);
    endtask

    task automatic run_job(input int unsigned k, input int unsigned t, input bit vhigh,
                           input int unsigned dmin, input int unsigned dmax, input string tag);
        logic [6:0]  o;
        logic [6:0]  e;
        int unsigned acc;
        int unsigned budget;
        int unsigned d;
        int unsigned w;
        k_len = KW'(k);
        tiles = TW'(t);
        start = 1'b1;
        clear = 1'b0;
        arr_if.psum_valid_i     = 1'b1;
        arr_if.tile_calc_over_i = 1'b0;
        arr_if.drain_ready_i    = 1'($urandom_range(1, 0));
        @(negedge clk);
        o = outs();
        n_total++;
        if (o[5:0] !== 6'b000000) $display("FAIL %s start_idle act=%b exp=000000", tag, o[5:0]);
        else n_pass++;
        tick();
        start = 1'b0;
        if (k == 0 || t == 0) begin
            @(negedge clk);
            o = outs(); e = 7'b0000011;
            n_total++;
            if (o !== e) $display("FAIL %s zero_fin act=%b exp=%b", tag, o, e);
            else n_pass++;
            tick();
            @(negedge clk);
            o = outs(); e = 7'b0000000;
            n_total++;
            if (o !== e) $display("FAIL %s zero_idle act=%b exp=%b", tag, o, e);
            else n_pass++;
            tick();
            return;
        end
        for (int unsigned j = 0; j < t; j++) begin
            acc = 0;
            budget = 0;
            while (acc < k && budget < 4 * k + 20) begin
                arr_if.psum_valid_i     = vhigh ? 1'b1 : ($urandom_range(2, 0) != 0);
                arr_if.drain_ready_i    = 1'($urandom_range(1, 0));
                arr_if.tile_calc_over_i = ($urandom_range(9, 0) == 0);
                rand_start();
                @(negedge clk);
                o = outs();
                e = {1'b0, 1'b1, arr_if.psum_valid_i, arr_if.psum_valid_i && (acc == 0), 1'b0, 1'b1, 1'b0};
                n_total++;
                if (o !== e) $display("FAIL %s accum tile=%0d wave=%0d act=%b exp=%b", tag, j, acc, o, e);
                else n_pass++;
                n_total++;
                if (tile_idx !== TW'(j)) $display("FAIL %s accum_tile_idx act=%0d exp=%0d", tag, tile_idx, j);
                else n_pass++;
                if (arr_if.psum_valid_i) acc++;
                budget++;
                tick();
            end
            n_total++;
            if (acc != k) $display("FAIL %s accept_budget tile=%0d act=%0d exp=%0d", tag, j, acc, k);
            else n_pass++;
            d = $urandom_range(dmax, dmin);
            repeat (d) begin
                arr_if.drain_ready_i    = 1'b0;
                arr_if.psum_valid_i     = 1'($urandom_range(1, 0));
                arr_if.tile_calc_over_i = ($urandom_range(9, 0) == 0);
                rand_start();
                @(negedge clk);
                o = outs(); e = 7'b0000010;
                n_total++;
                if (o !== e) $display("FAIL %s drain_wait tile=%0d act=%b exp=%b", tag, j, o, e);
                else n_pass++;
                tick();
            end
            arr_if.drain_ready_i = 1'b1;
            @(negedge clk);
            o = outs(); e = 7'b0000010;
            n_total++;
            if (o !== e) $display("FAIL %s drain_ready_rise tile=%0d act=%b exp=%b", tag, j, o, e);
            else n_pass++;
            tick();
            for (int unsigned c = 0; c < SIZE; c++) begin
                arr_if.drain_ready_i    = 1'($urandom_range(1, 0));
                arr_if.psum_valid_i     = 1'($urandom_range(1, 0));
                arr_if.tile_calc_over_i = ($urandom_range(9, 0) == 0);
                rand_start();
                @(negedge clk);
                o = outs(); e = 7'b0000110;
                n_total++;
                if (o !== e) $display("FAIL %s drain tile=%0d cyc=%0d act=%b exp=%b", tag, j, c, o, e);
                else n_pass++;
                tick();
            end
            w = $urandom_range(6, 0);
            arr_if.tile_calc_over_i = 1'b0;
            repeat (w) begin
                arr_if.drain_ready_i = 1'($urandom_range(1, 0));
                arr_if.psum_valid_i  = 1'($urandom_range(1, 0));
                rand_start();
                @(negedge clk);
                o = outs(); e = 7'b0000010;
                n_total++;
                if (o !== e) $display("FAIL %s wait_over tile=%0d act=%b exp=%b", tag, j, o, e);
                else n_pass++;
                tick();
            end
            arr_if.tile_calc_over_i = 1'b1;
            @(negedge clk);
            o = outs(); e = 7'b0000010;
            n_total++;
            if (o !== e) $display("FAIL %s over_pulse tile=%0d act=%b exp=%b", tag, j, o, e);
            else n_pass++;
            tick();
            arr_if.tile_calc_over_i = 1'b0;
        end
        start = 1'b0;
        @(negedge clk);
        o = outs(); e = 7'b0000011;
        n_total++;
        if (o !== e) $display("FAIL %s fin act=%b exp=%b", tag, o, e);
        else n_pass++;
        tick();
        @(negedge clk);
        o = outs(); e = 7'b0000000;
        n_total++;
        if (o !== e) $display("FAIL %s idle_after act=%b exp=%b", tag, o, e);
        else n_pass++;
        n_total++;
        if (tile_idx !== TW'(t - 1)) $display("FAIL %s tile_idx_hold act=%0d exp=%0d", tag, tile_idx, t - 1);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        k_len = 16'd3;
        tiles = 12'd2;
        clear = 1'b0;
        arr_if.psum_valid_i     = 1'b1;
        arr_if.drain_ready_i    = 1'b1;
        arr_if.tile_calc_over_i = 1'b1;
        #12;
        n_total++;
        if (outs() !== 7'b0000000) $display("FAIL reset_outs act=%b exp=0000000", outs());
        else n_pass++;
        n_total++;
        if (tile_idx !== '0) $display("FAIL reset_tile_idx act=%0d exp=0", tile_idx);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        arr_if.tile_calc_over_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_total++;
            if (outs() !== 7'b0000000) $display("FAIL reset_idle act=%b exp=0000000", outs());
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_single_tile();
        run_job(4, 1, 1'b1, 0, 0, "single_tile");
    endtask

    task automatic test_multi_tile();
        run_job(1, 3, 1'b0, 0, 3, "multi_tile");
    endtask

    task automatic test_backpressure();
        run_job(2, 1, 1'b0, 10, 10, "backpressure");
    endtask

    task automatic test_zero_config();
        run_job(0, 5, 1'b1, 0, 0, "zero_k");
        run_job(3, 0, 1'b1, 0, 0, "zero_t");
    endtask

    task automatic test_clear();
        start = 1'b1; k_len = 16'd4; tiles = 12'd2;
        arr_if.psum_valid_i = 1'b1; arr_if.drain_ready_i = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        tick();
        for (int unsigned c = 0; c < 5; c++) begin
            @(negedge clk);
            n_total++;
            if (arr_if.acc_calc_done_o !== 1'b1) $display("FAIL clear_pre_drain cyc=%0d act=%b exp=1", c, arr_if.acc_calc_done_o);
            else n_pass++;
            tick();
        end
        clear = 1'b1;
        @(negedge clk);
        n_total++;
        if (outs() !== 7'b0000110) $display("FAIL clear_cycle act=%b exp=0000110", outs());
        else n_pass++;
        tick();
        clear = 1'b0;
        repeat (20) begin
            arr_if.psum_valid_i     = 1'($urandom_range(1, 0));
            arr_if.tile_calc_over_i = 1'($urandom_range(1, 0));
            @(negedge clk);
            n_total++;
            if (outs() !== 7'b0000000) $display("FAIL clear_after act=%b exp=0000000", outs());
            else n_pass++;
            n_total++;
            if (tile_idx !== '0) $display("FAIL clear_tile_idx act=%0d exp=0", tile_idx);
            else n_pass++;
            tick();
        end
        arr_if.tile_calc_over_i = 1'b0;
        run_job(2, 2, 1'b0, 0, 2, "after_clear");
    endtask

    task automatic test_reset_mid();
        start = 1'b1; k_len = 16'd5; tiles = 12'd1;
        arr_if.psum_valid_i = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        n_total++;
        if (outs() !== 7'b0110010) $display("FAIL reset_mid_pre act=%b exp=0110010", outs());
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (outs() !== 7'b0000000) $display("FAIL reset_mid_async act=%b exp=0000000", outs());
        else n_pass++;
        tick();
        rst_n = 1'b1;
        repeat (20) begin
            arr_if.psum_valid_i     = 1'($urandom_range(1, 0));
            arr_if.tile_calc_over_i = 1'($urandom_range(1, 0));
            @(negedge clk);
            n_total++;
            if (outs() !== 7'b0000000) $display("FAIL reset_mid_after act=%b exp=0000000", outs());
            else n_pass++;
            tick();
        end
        arr_if.tile_calc_over_i = 1'b0;
    endtask

    task automatic test_watchdog();
        start = 1'b1; k_len = 16'd1; tiles = 12'd1;
        arr_if.psum_valid_i = 1'b0; arr_if.tile_calc_over_i = 1'b0;
        tick();
        start = 1'b0;
        arr_if.psum_valid_i = 1'b1; arr_if.drain_ready_i = 1'b1;
        tick();
        arr_if.psum_valid_i = 1'b0;
        tick();
        repeat (SIZE) tick();
`ifdef ACC_SEQ_WATCHDOG_EN
        for (int unsigned c = 0; c < TMO; c++) begin
            @(negedge clk);
            n_total++;
            if (outs() !== 7'b0000010) $display("FAIL wd_wait cyc=%0d act=%b exp=0000010", c, outs());
            else n_pass++;
            tick();
        end
        @(negedge clk);
        n_total++;
        if (outs() !== 7'b1000000) $display("FAIL wd_trip act=%b exp=1000000", outs());
        else n_pass++;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        n_total++;
        if (outs() !== 7'b1000000) $display("FAIL wd_err_sticky act=%b exp=1000000", outs());
        else n_pass++;
        tick();
        run_job(1, 1, 1'b1, 0, 1, "wd_restart");
`else
        repeat (40) begin
            @(negedge clk);
            n_total++;
            if (outs() !== 7'b0000010) $display("FAIL wait_forever act=%b exp=0000010", outs());
            else n_pass++;
            tick();
        end
        arr_if.tile_calc_over_i = 1'b1;
        tick();
        arr_if.tile_calc_over_i = 1'b0;
        @(negedge clk);
        n_total++;
        if (outs() !== 7'b0000011) $display("FAIL wait_forever_fin act=%b exp=0000011", outs());
        else n_pass++;
        tick();
`endif
    endtask

    task automatic test_random_jobs();
        for (int unsigned i = 0; i < 6; i++) begin
            run_job($urandom_range(6, 1), $urandom_range(3, 1), 1'b0, 0, 4, "random_job");
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_multi_tile();
        test_backpressure();
        test_zero_config();
        test_clear();
        test_reset_mid();
        test_watchdog();
        test_random_jobs();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
